// File: rtl/peripheral_dbg_pu_riscv_jsp_biu_apb4_mc.sv
// ---------------------------------------------------------------------------
// PeripheralDbgPuRiscvJspBiuApb4Mc
//
// Multi-channel JTAG-serial-port bus interface seen from an APB4 slave.
// Every channel owns two byte FIFOs:
//   h2c : filled by the debug (host) side, drained by APB DATA reads
//   c2h : filled by APB DATA writes, drained by the debug (host) side
// Register map per channel (channel = PADDR[7:4], offset = PADDR[3:0]):
//   0x0 DATA   read pops h2c head, write pushes c2h
//   0x4 STATUS [7:0] h2c count, [15:8] c2h free space, [16] overflow (W1C)
//   0x8 IER    [0] rx-data interrupt enable, [1] tx-empty interrupt enable
//   0xC        reads 0, writes ignored
//
// Ports:
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE    APB4 control, PADDR byte address, PWDATA data
//   PRDATA/PREADY/PSLVERR  APB4 response (zero wait states)
//   h2c_data/valid/ready   host-to-core push interface, one byte lane each
//   c2h_data/valid/ready   core-to-host first-word-fallthrough pop interface
//   int_o                  registered OR of all channel interrupts
// ---------------------------------------------------------------------------
module peripheral_dbg_pu_riscv_jsp_biu_apb4_mc #(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [7:0]            PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [CHANNELS*8-1:0] h2c_data,
    input  logic [CHANNELS-1:0]   h2c_valid,
    output logic [CHANNELS-1:0]   h2c_ready,
    output logic [CHANNELS*8-1:0] c2h_data,
    output logic [CHANNELS-1:0]   c2h_valid,
    input  logic [CHANNELS-1:0]   c2h_ready,
    output logic                  int_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Access decode. Gating with PRESETn keeps every APB side effect and
    // response quiet while the block is held in reset.
    logic        w_access;
    logic [3:0]  w_chIdx;
    logic [3:0]  w_offset;
    logic        w_chValid;
    logic        w_isData;
    logic        w_isStatus;
    logic        w_isIer;

    assign w_access   = PSEL & PENABLE & PRESETn;
    assign w_chIdx    = PADDR[7:4];
    assign w_offset   = PADDR[3:0];
    assign w_chValid  = ({28'd0, w_chIdx} < 32'(CHANNELS));
    assign w_isData   = (w_offset == 4'h0);
    assign w_isStatus = (w_offset == 4'h4);
    assign w_isIer    = (w_offset == 4'h8);

    logic [CHANNELS-1:0] w_sel;
    logic [CHANNELS-1:0] w_h2cEmpty;
    logic [CHANNELS-1:0] w_h2cPop;
    logic [CHANNELS-1:0] w_c2hDrop;
    logic [CHANNELS-1:0] w_irq;
    logic [7:0]          w_h2cHead [CHANNELS];
    logic [31:0]         w_status  [CHANNELS];
    logic [1:0]          w_ier     [CHANNELS];

    logic  r_int;
    logic  w_unusedBits;

    assign w_unusedBits = ^{PWDATA[31:17], PWDATA[15:8]};

    for (genvar g = 0; g < CHANNELS; g++) begin : gChannel
        logic [7:0]    r_h2cMem [DEPTH];
        logic [7:0]    r_c2hMem [DEPTH];
        logic [AW-1:0] r_h2cWr;
        logic [AW-1:0] r_h2cRd;
        logic [AW-1:0] r_c2hWr;
        logic [AW-1:0] r_c2hRd;
        logic [CW-1:0] r_h2cCount;
        logic [CW-1:0] r_c2hCount;
        logic [1:0]    r_ier;
        logic          r_ovf;
        logic          w_h2cPush;
        logic          w_c2hPush;
        logic          w_c2hPop;
        logic          w_c2hFull;
        logic          w_dataWrite;

        assign w_sel[g]      = w_access & (w_chIdx == 4'(g));
        assign w_h2cEmpty[g] = (r_h2cCount == '0);
        assign w_c2hFull     = (r_c2hCount == FULL_COUNT);
        assign w_dataWrite   = w_sel[g] & PWRITE & w_isData;

        // A full FIFO still accepts a byte in the cycle its head leaves,
        // so a simultaneous push/pop never stalls or loses data.
        assign w_h2cPop[g]  = w_sel[g] & ~PWRITE & w_isData & ~w_h2cEmpty[g];
        assign h2c_ready[g] = (r_h2cCount != FULL_COUNT) | w_h2cPop[g];
        assign w_h2cPush    = h2c_valid[g] & h2c_ready[g];

        assign c2h_valid[g]  = (r_c2hCount != '0);
        assign w_c2hPop      = c2h_valid[g] & c2h_ready[g];
        assign w_c2hPush     = w_dataWrite & (~w_c2hFull | w_c2hPop);
        assign w_c2hDrop[g]  = w_dataWrite & w_c2hFull & ~w_c2hPop;

        assign c2h_data[g*8 +: 8] = r_c2hMem[r_c2hRd];
        assign w_h2cHead[g]       = r_h2cMem[r_h2cRd];
        assign w_ier[g]           = r_ier;
        assign w_status[g]        = {15'd0, r_ovf, 8'(DEPTH) - 8'(r_c2hCount), 8'(r_h2cCount)};

        assign w_irq[g] = (r_ier[0] & ~w_h2cEmpty[g]) | (r_ier[1] & (r_c2hCount == '0));

        // FIFO storage is not reset; clearing the pointers and counts is
        // enough to make any stale bytes unreachable.
        always_ff @(posedge PCLK) begin
            if (w_h2cPush) r_h2cMem[r_h2cWr] <= h2c_data[g*8 +: 8];
            if (w_c2hPush) r_c2hMem[r_c2hWr] <= PWDATA[7:0];
        end

        // Pointers wrap naturally because DEPTH is a power of two.
        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                r_h2cWr    <= '0;
                r_h2cRd    <= '0;
                r_h2cCount <= '0;
                r_c2hWr    <= '0;
                r_c2hRd    <= '0;
                r_c2hCount <= '0;
            end else begin
                if (w_h2cPush)   r_h2cWr <= r_h2cWr + AW'(1);
                if (w_h2cPop[g]) r_h2cRd <= r_h2cRd + AW'(1);
                if (w_c2hPush)   r_c2hWr <= r_c2hWr + AW'(1);
                if (w_c2hPop)    r_c2hRd <= r_c2hRd + AW'(1);
                case ({w_h2cPush, w_h2cPop[g]})
                    2'b10:   r_h2cCount <= r_h2cCount + CW'(1);
                    2'b01:   r_h2cCount <= r_h2cCount - CW'(1);
                    default: r_h2cCount <= r_h2cCount;
                endcase
                case ({w_c2hPush, w_c2hPop})
                    2'b10:   r_c2hCount <= r_c2hCount + CW'(1);
                    2'b01:   r_c2hCount <= r_c2hCount - CW'(1);
                    default: r_c2hCount <= r_c2hCount;
                endcase
            end
        end

        // Interrupt enables and the sticky overflow flag (write-1-to-clear).
        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                r_ier <= 2'b00;
                r_ovf <= 1'b0;
            end else begin
                if (w_sel[g] & PWRITE & w_isIer) r_ier <= PWDATA[1:0];
                if (w_c2hDrop[g]) begin
                    r_ovf <= 1'b1;
                end else if (w_sel[g] & PWRITE & w_isStatus & PWDATA[16]) begin
                    r_ovf <= 1'b0;
                end
            end
        end
    end

    // Read data mux; stays zero outside a read access phase and for an
    // empty DATA read, so a failed pop never exposes a stale byte.
    always_comb begin
        PRDATA = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_access && !PWRITE && (w_chIdx == 4'(c))) begin
                case (w_offset)
                    4'h0:    if (!w_h2cEmpty[c]) PRDATA = {24'd0, w_h2cHead[c]};
                    4'h4:    PRDATA = w_status[c];
                    4'h8:    PRDATA = {30'd0, w_ier[c]};
                    default: PRDATA = '0;
                endcase
            end
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = w_access & (~w_chValid
                               | (~PWRITE & w_isData & |(w_sel & w_h2cEmpty))
                               | (|w_c2hDrop));

    // The combined interrupt is registered to give a glitch-free output.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_int <= 1'b0;
        else          r_int <= |w_irq;
    end

    assign int_o = r_int;

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_jsp_biu_apb4_mc.sv
// ---------------------------------------------------------------------------
// Testbench for peripheral_dbg_pu_riscv_jsp_biu_apb4_mc (CHANNELS=2, DEPTH=8).
// Table-driven register vectors, hand-written multi-cycle sequences and a
// randomized phase compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_peripheral_dbg_pu_riscv_jsp_biu_apb4_mc;

    localparam int CH    = 2;
    localparam int DEPTH = 8;

    logic          clock;
    logic          presetN;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [7:0]    paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;
    logic [CH*8-1:0] h2cData;
    logic [CH-1:0] h2cValid;
    logic [CH-1:0] h2cReady;
    logic [CH*8-1:0] c2hData;
    logic [CH-1:0] c2hValid;
    logic [CH-1:0] c2hReady;
    logic          intO;

    int checkCount;
    int errorCount;

    peripheral_dbg_pu_riscv_jsp_biu_apb4_mc #(
        .CHANNELS(CH),
        .DEPTH(DEPTH)
    ) dut (
        .PCLK(clock),
        .PRESETn(presetN),
        .PSEL(psel),
        .PENABLE(penable),
        .PWRITE(pwrite),
        .PADDR(paddr),
        .PWDATA(pwdata),
        .PRDATA(prdata),
        .PREADY(pready),
        .PSLVERR(pslverr),
        .h2c_data(h2cData),
        .h2c_valid(h2cValid),
        .h2c_ready(h2cReady),
        .c2h_data(c2hData),
        .c2h_valid(c2hValid),
        .c2h_ready(c2hReady),
        .int_o(intO)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRd;
        logic        expErr;
    } vec_t;

    vec_t vecs [18];

    // Reference model state
    logic [7:0] h2cQ [CH][$];
    logic [7:0] c2hQ [CH][$];
    logic [1:0] mIer [CH];
    logic       mOvf [CH];
    logic       mInt;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // One complete APB transfer: setup phase, access phase (sampled #1 after
    // the falling edge), then bus returns idle on the next falling edge.
    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err);
        @(negedge clock);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(negedge clock);
        penable = 1'b1;
        #1;
        rdata = prdata;
        err   = pslverr;
        checkOutput("pready", {31'd0, pready}, 32'd1);
        @(negedge clock);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apbCheck(input string name, input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                            input logic [31:0] expRd, input logic expErr);
        logic [31:0] rd;
        logic        err;
        applyStimulus(wr, addr, wdata, rd, err);
        checkOutput({name, ".prdata"}, rd, expRd);
        checkOutput({name, ".pslverr"}, {31'd0, err}, {31'd0, expErr});
    endtask

    task automatic pushH2c(input int ch, input logic [7:0] b);
        @(negedge clock);
        h2cValid[ch] = 1'b1;
        h2cData[ch*8 +: 8] = b;
        @(negedge clock);
        h2cValid[ch] = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clock);
        presetN = 1'b0;
        repeat (2) @(negedge clock);
        presetN = 1'b1;
    endtask

    task automatic resetModel();
        for (int c = 0; c < CH; c++) begin
            h2cQ[c].delete();
            c2hQ[c].delete();
            mIer[c] = 2'b00;
            mOvf[c] = 1'b0;
        end
        mInt = 1'b0;
    endtask

    // Randomized traffic: every cycle's outputs are predicted from the
    // queues, then the queues advance by the rules of the register map.
    task automatic randomPhase(input int cycles);
        int          chi;
        logic [3:0]  off;
        logic        acc;
        logic        chOk;
        logic        expErr;
        logic        irqNow;
        logic [31:0] expRd;
        logic [CH-1:0] popH2c;
        logic [CH-1:0] popC2h;
        logic [CH-1:0] expReady;
        int          mode;
        int          r;
        int          c2hSize;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clock);
            for (int c = 0; c < CH; c++) begin
                h2cValid[c] = ($urandom_range(0, 5) == 0);
                c2hReady[c] = ($urandom_range(0, 5) == 0);
            end
            h2cData = 16'($urandom);
            mode    = $urandom_range(0, 3);
            psel    = (mode != 0);
            penable = (mode >= 2);
            pwrite  = 1'($urandom);
            r       = $urandom_range(0, 5);
            off     = (r <= 2) ? 4'h0 : (r == 3) ? 4'h4 : (r == 4) ? 4'h8 : 4'hC;
            chi     = $urandom_range(0, CH);
            paddr   = {4'(chi), off};
            pwdata  = $urandom;
            #1;
            acc  = psel && penable;
            chOk = chi < CH;
            for (int c = 0; c < CH; c++) begin
                popH2c[c]   = acc && !pwrite && off == 4'h0 && chi == c && h2cQ[c].size() > 0;
                expReady[c] = (h2cQ[c].size() < DEPTH) || popH2c[c];
                popC2h[c]   = (c2hQ[c].size() > 0) && c2hReady[c];
            end
            expRd = 32'd0;
            if (acc && !pwrite && chOk) begin
                case (off)
                    4'h0: expRd = (h2cQ[chi].size() > 0) ? {24'd0, h2cQ[chi][0]} : 32'd0;
                    4'h4: expRd = {15'd0, mOvf[chi], 8'(DEPTH - c2hQ[chi].size()), 8'(h2cQ[chi].size())};
                    4'h8: expRd = {30'd0, mIer[chi]};
                    default: expRd = 32'd0;
                endcase
            end
            expErr = acc && (!chOk
                             || (!pwrite && off == 4'h0 && h2cQ[chi].size() == 0)
                             || (pwrite && off == 4'h0 && c2hQ[chi].size() == DEPTH && !popC2h[chi]));
            checkOutput($sformatf("rand%0d.prdata", cyc), prdata, expRd);
            checkOutput($sformatf("rand%0d.pslverr", cyc), {31'd0, pslverr}, {31'd0, expErr});
            checkOutput($sformatf("rand%0d.int_o", cyc), {31'd0, intO}, {31'd0, mInt});
            checkOutput($sformatf("rand%0d.h2c_ready", cyc), {30'd0, h2cReady}, {30'd0, expReady});
            for (int c = 0; c < CH; c++) begin
                checkOutput($sformatf("rand%0d.c2h_valid%0d", cyc, c), {31'd0, c2hValid[c]},
                            {31'd0, (c2hQ[c].size() > 0)});
                if (c2hQ[c].size() > 0)
                    checkOutput($sformatf("rand%0d.c2h_data%0d", cyc, c), {24'd0, c2hData[c*8 +: 8]},
                                {24'd0, c2hQ[c][0]});
            end
            // Advance the model to the state after the coming rising edge.
            irqNow = 1'b0;
            for (int c = 0; c < CH; c++)
                irqNow |= (mIer[c][0] && h2cQ[c].size() != 0) || (mIer[c][1] && c2hQ[c].size() == 0);
            mInt = irqNow;
            for (int c = 0; c < CH; c++) begin
                if (popH2c[c]) void'(h2cQ[c].pop_front());
                if (h2cValid[c] && expReady[c]) h2cQ[c].push_back(h2cData[c*8 +: 8]);
                c2hSize = c2hQ[c].size();
                if (popC2h[c]) void'(c2hQ[c].pop_front());
                if (acc && pwrite && chi == c) begin
                    if (off == 4'h0) begin
                        if (c2hSize < DEPTH || popC2h[c]) c2hQ[c].push_back(pwdata[7:0]);
                        else mOvf[c] = 1'b1;
                    end else if (off == 4'h4 && pwdata[16]) begin
                        mOvf[c] = 1'b0;
                    end else if (off == 4'h8) begin
                        mIer[c] = pwdata[1:0];
                    end
                end
            end
        end
        @(negedge clock);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; h2cValid = '0; c2hReady = '0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;

        checkCount = 0;
        errorCount = 0;
        presetN  = 1'b0;
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = 8'h00;
        pwdata   = 32'h0;
        h2cData  = '0;
        h2cValid = '0;
        c2hReady = '0;

        vecs[0]  = '{1'b0, 8'h04, 32'h0,        32'h0000_0800, 1'b0};
        vecs[1]  = '{1'b0, 8'h14, 32'h0,        32'h0000_0800, 1'b0};
        vecs[2]  = '{1'b1, 8'h08, 32'h3,        32'h0,         1'b0};
        vecs[3]  = '{1'b0, 8'h08, 32'h0,        32'h3,         1'b0};
        vecs[4]  = '{1'b1, 8'h08, 32'hFFFF_FFFC, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 8'h08, 32'h0,        32'h0,         1'b0};
        vecs[6]  = '{1'b0, 8'h0C, 32'h0,        32'h0,         1'b0};
        vecs[7]  = '{1'b1, 8'h0C, 32'hFFFF_FFFF, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 8'h0C, 32'h0,        32'h0,         1'b0};
        vecs[9]  = '{1'b0, 8'h20, 32'h0,        32'h0,         1'b1};
        vecs[10] = '{1'b1, 8'h20, 32'h1,        32'h0,         1'b1};
        vecs[11] = '{1'b0, 8'h00, 32'h0,        32'h0,         1'b1};
        vecs[12] = '{1'b1, 8'h00, 32'hA5,       32'h0,         1'b0};
        vecs[13] = '{1'b0, 8'h04, 32'h0,        32'h0000_0700, 1'b0};
        vecs[14] = '{1'b1, 8'h18, 32'h2,        32'h0,         1'b0};
        vecs[15] = '{1'b0, 8'h18, 32'h0,        32'h2,         1'b0};
        vecs[16] = '{1'b1, 8'h18, 32'h0,        32'h0,         1'b0};
        vecs[17] = '{1'b0, 8'h3C, 32'h0,        32'h0,         1'b1};

        // Reset state, with an access phase driven to prove responses are gated.
        repeat (2) @(negedge clock);
        psel = 1'b1; penable = 1'b1; paddr = 8'h20;
        #1;
        checkOutput("reset.prdata", prdata, 32'h0);
        checkOutput("reset.pslverr", {31'd0, pslverr}, 32'h0);
        checkOutput("reset.h2c_ready", {30'd0, h2cReady}, 32'h3);
        checkOutput("reset.c2h_valid", {30'd0, c2hValid}, 32'h0);
        checkOutput("reset.int_o", {31'd0, intO}, 32'h0);
        @(negedge clock);
        psel = 1'b0; penable = 1'b0; paddr = 8'h00;
        presetN = 1'b1;

        // Register-map vectors
        for (int i = 0; i < 18; i++)
            apbCheck($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].expRd, vecs[i].expErr);
        checkOutput("vec.c2h_valid", {30'd0, c2hValid}, 32'h1);
        checkOutput("vec.c2h_data", {24'd0, c2hData[7:0]}, 32'hA5);
        @(negedge clock); c2hReady[0] = 1'b1;
        @(negedge clock); c2hReady[0] = 1'b0;
        #1 checkOutput("vec.c2h_drained", {30'd0, c2hValid}, 32'h0);

        // h2c ordering on channel 1
        doReset();
        pushH2c(1, 8'h41);
        pushH2c(1, 8'h42);
        pushH2c(1, 8'h43);
        apbCheck("ch1.rd0", 1'b0, 8'h10, 32'h0, 32'h41, 1'b0);
        apbCheck("ch1.rd1", 1'b0, 8'h10, 32'h0, 32'h42, 1'b0);
        apbCheck("ch1.rd2", 1'b0, 8'h10, 32'h0, 32'h43, 1'b0);
        apbCheck("ch1.status", 1'b0, 8'h14, 32'h0, 32'h0000_0800, 1'b0);

        // c2h overflow and W1C clear on channel 0
        for (int i = 0; i < 9; i++)
            apbCheck($sformatf("ovf.wr%0d", i), 1'b1, 8'h00, 32'(8'h60 + i), 32'h0, (i == 8));
        apbCheck("ovf.status", 1'b0, 8'h04, 32'h0, 32'h0001_0000, 1'b0);
        apbCheck("ovf.clear", 1'b1, 8'h04, 32'h0001_0000, 32'h0, 1'b0);
        apbCheck("ovf.cleared", 1'b0, 8'h04, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checkOutput($sformatf("ovf.c2h%0d", i), {24'd0, c2hData[7:0]}, 32'(8'h60 + i));
            c2hReady[0] = 1'b1;
        end
        @(negedge clock);
        c2hReady[0] = 1'b0;
        #1 checkOutput("ovf.c2h_empty", {31'd0, c2hValid[0]}, 32'h0);

        // Empty DATA read
        apbCheck("empty.status0", 1'b0, 8'h04, 32'h0, 32'h0000_0800, 1'b0);
        apbCheck("empty.read", 1'b0, 8'h00, 32'h0, 32'h0, 1'b1);
        apbCheck("empty.status1", 1'b0, 8'h04, 32'h0, 32'h0000_0800, 1'b0);

        // Interrupt latency
        apbCheck("irq.ier", 1'b1, 8'h08, 32'h1, 32'h0, 1'b0);
        pushH2c(0, 8'h77);
        #1 checkOutput("irq.lag", {31'd0, intO}, 32'h0);
        @(negedge clock);
        #1 checkOutput("irq.set", {31'd0, intO}, 32'h1);
        apbCheck("irq.pop", 1'b0, 8'h00, 32'h0, 32'h77, 1'b0);
        checkOutput("irq.held", {31'd0, intO}, 32'h1);
        @(negedge clock);
        #1 checkOutput("irq.clr", {31'd0, intO}, 32'h0);
        apbCheck("irq.ieroff", 1'b1, 8'h08, 32'h0, 32'h0, 1'b0);

        // Simultaneous push and pop on a full h2c FIFO
        doReset();
        for (int i = 0; i < 8; i++) pushH2c(0, 8'(8'h10 + i));
        #1 checkOutput("full.h2c_ready", {31'd0, h2cReady[0]}, 32'h0);
        @(negedge clock);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00;
        @(negedge clock);
        penable = 1'b1; h2cValid[0] = 1'b1; h2cData[7:0] = 8'h55;
        #1;
        checkOutput("full.ready_pass", {31'd0, h2cReady[0]}, 32'h1);
        checkOutput("full.rd_head", prdata, 32'h10);
        checkOutput("full.rd_err", {31'd0, pslverr}, 32'h0);
        @(negedge clock);
        psel = 1'b0; penable = 1'b0; h2cValid[0] = 1'b0;
        apbCheck("full.status", 1'b0, 8'h04, 32'h0, 32'h0000_0808, 1'b0);
        for (int i = 1; i < 8; i++)
            apbCheck($sformatf("full.rd%0d", i), 1'b0, 8'h00, 32'h0, 32'(8'h10 + i), 1'b0);
        apbCheck("full.rd_last", 1'b0, 8'h00, 32'h0, 32'h55, 1'b0);
        apbCheck("full.status_end", 1'b0, 8'h04, 32'h0, 32'h0000_0800, 1'b0);

        // Reset asserted mid-stream
        pushH2c(0, 8'hC1);
        pushH2c(0, 8'hC2);
        apbCheck("mid.ier", 1'b1, 8'h08, 32'h1, 32'h0, 1'b0);
        apbCheck("mid.wr", 1'b1, 8'h10, 32'h99, 32'h0, 1'b0);
        #1 checkOutput("mid.int_before", {31'd0, intO}, 32'h1);
        @(negedge clock);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h00;
        presetN = 1'b0;
        #1;
        checkOutput("mid.int_o", {31'd0, intO}, 32'h0);
        checkOutput("mid.h2c_ready", {30'd0, h2cReady}, 32'h3);
        checkOutput("mid.c2h_valid", {30'd0, c2hValid}, 32'h0);
        checkOutput("mid.prdata", prdata, 32'h0);
        checkOutput("mid.pslverr", {31'd0, pslverr}, 32'h0);
        @(negedge clock);
        psel = 1'b0; penable = 1'b0;
        presetN = 1'b1;
        apbCheck("mid.status0", 1'b0, 8'h04, 32'h0, 32'h0000_0800, 1'b0);
        apbCheck("mid.status1", 1'b0, 8'h14, 32'h0, 32'h0000_0800, 1'b0);
        apbCheck("mid.read", 1'b0, 8'h00, 32'h0, 32'h0, 1'b1);
        apbCheck("mid.ier_clr", 1'b0, 8'h08, 32'h0, 32'h0, 1'b0);

        // Randomized traffic against the reference model
        doReset();
        resetModel();
        randomPhase(3000);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/peripheral_dbg_pu_riscv_jsp_biu_apb4_mc.md
PERIPHERAL_DBG_PU_RISCV_JSP_BIU_APB4_MC -- requirements
Module: peripheral_dbg_pu_riscv_jsp_biu_apb4_mc

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 2, meaning the number of independent JSP channels (1..8).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the byte depth of each FIFO (power of 2, 2..256).
REQ-003 The block SHALL have the following ports:
- PCLK  in  1  sole clock.
- PRESETn  in  1  asynchronous, active-low reset.
- PSEL, PENABLE, PWRITE  in  1 each  APB4 control.
- PADDR  in  8  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY, PSLVERR  out  1 each  APB4 response.
- h2c_data  in  CHANNELS*8  host-to-core bytes, 8 bits per channel.
- h2c_valid  in  CHANNELS  host-to-core push request per channel.
- h2c_ready  out  CHANNELS  host-to-core FIFO not full.
- c2h_data  out  CHANNELS*8  core-to-host FIFO head bytes.
- c2h_valid  out  CHANNELS  core-to-host FIFO not empty.
- c2h_ready  in  CHANNELS  core-to-host pop per channel.
- int_o  out  1  combined interrupt, registered.

Function
REQ-004 Each channel SHALL own one h2c FIFO and one c2h FIFO, each DEPTH bytes, with occupancy counters of width clog2(DEPTH+1).
REQ-005 The debug side SHALL push h2c on h2c_valid&h2c_ready and pop c2h on c2h_valid&c2h_ready, one byte per channel per cycle.
REQ-006 c2h_data SHALL be first-word-fallthrough: the head byte is valid in the same cycle c2h_valid=1.
REQ-007 An APB access SHALL occur on PSEL&PENABLE; PREADY SHALL be constantly 1 (zero wait states).
REQ-008 Channel index SHALL be PADDR[7:4]; register offset SHALL be PADDR[3:0].
REQ-009 Offset 0x0 DATA: a read SHALL return {24'b0, h2c head} and pop h2c; a write SHALL push PWDATA[7:0] into c2h.
REQ-010 Offset 0x4 STATUS: a read SHALL return bits[7:0]=h2c count, [15:8]=c2h free space, [16]=overflow sticky, others 0.
REQ-011 A STATUS write with PWDATA[16]=1 SHALL clear the overflow sticky bit (write-1-to-clear).
REQ-012 Offset 0x8 IER: read/write, bit0 enables rx interrupt, bit1 enables tx-empty interrupt; other bits read 0.
REQ-013 Offset 0xC SHALL read 0 and ignore writes.
REQ-014 PSLVERR SHALL be 1 during the access phase when any of the following holds: channel index >= CHANNELS; DATA read with h2c empty; DATA write with c2h full.
REQ-015 A DATA read with h2c empty SHALL return 0 and not change the h2c pointers.
REQ-016 A DATA write with c2h full SHALL drop the byte and set the overflow sticky bit.
REQ-017 A simultaneous push and pop on the same FIFO SHALL leave its count unchanged and preserve byte order, including when the FIFO is full or empty-with-FWT.
REQ-018 Pointers SHALL wrap modulo DEPTH; counts SHALL never exceed DEPTH or go below 0.
REQ-019 For channel c, irq_c = (IER[0] & h2c count!=0) | (IER[1] & c2h count==0).
REQ-020 int_o SHALL equal the registered OR of all irq_c, lagging the condition by one PCLK cycle.
REQ-021 PRDATA SHALL be 0 whenever no read access phase is active.

Reset
REQ-022 On PRESETn=0 the block SHALL asynchronously clear all pointers, counts, IER and overflow bits, and int_o.
REQ-023 During reset, h2c_ready SHALL be 1, c2h_valid 0, PRDATA 0 and PSLVERR 0.
REQ-024 Reset asserted mid-transfer SHALL discard all FIFO contents; the first access after release SHALL see empty FIFOs.

Verification
REQ-025 The bench SHALL push 0x41,0x42,0x43 on h2c ch1, then read 0x10 three times -> PRDATA 0x41,0x42,0x43; STATUS 0x14 then reads 0x00000800 (with DEPTH=8).
REQ-026 The bench SHALL write DATA ch0 nine times (DEPTH=8) with c2h_ready=0 -> the ninth write gets PSLVERR=1 and STATUS 0x04 reads 0x00010000; writing 0x00010000 to 0x04 then clears bit16.
REQ-027 The bench SHALL read 0x00 with h2c empty -> PRDATA=0, PSLVERR=1, and STATUS unchanged.
REQ-028 The bench SHALL set IER ch0=0x1 and push one byte -> int_o=1 one cycle after the count becomes 1; popping via DATA read -> int_o=0 one cycle later.
REQ-029 The bench SHALL access PADDR=0x20 with CHANNELS=2 -> PSLVERR=1, PRDATA=0, and no state change.
REQ-030 The bench SHALL fill h2c ch0 (8 bytes), then in one cycle push 0x55 while reading DATA -> count stays 8 and 0x55 is read last; asserting PRESETn=0 mid-stream -> all counts 0 and int_o=0 immediately.
